// File: rtl/pe_ws_param.sv
// Weight-stationary MAC processing element with configurable widths,
// signed/unsigned arithmetic, wrap/saturate accumulation and a
// double-buffered weight loaded over a daisy chain.
module pe_ws_param #(
    parameter int W_WIDTH  = 8,
    parameter int A_WIDTH  = 8,
    parameter int S_WIDTH  = 24,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [W_WIDTH-1:0] i_weight,
    input  logic               i_weight_load,
    input  logic               i_weight_swap,
    input  logic               i_valid,
    input  logic [A_WIDTH-1:0] i_activation,
    input  logic [S_WIDTH-1:0] i_sum,
    output logic [W_WIDTH-1:0] o_weight,
    output logic [A_WIDTH-1:0] o_activation,
    output logic               o_act_valid,
    output logic [S_WIDTH-1:0] o_sum,
    output logic               o_valid,
    output logic               o_ovf
);

    localparam int P_WIDTH = W_WIDTH + A_WIDTH;

    generate
        if (S_WIDTH < P_WIDTH) begin : g_width_check
            $error("pe_ws_param: S_WIDTH must be >= W_WIDTH + A_WIDTH");
        end
    endgenerate

    logic [W_WIDTH-1:0] shadow_q, shadow_d;
    logic [W_WIDTH-1:0] active_q, active_d;
    logic [A_WIDTH-1:0] act_q;
    logic               act_v_q;
    logic [P_WIDTH-1:0] prod_q, prod_d;
    logic [S_WIDTH-1:0] sum_q, sum_d;
    logic               v1_q;
    logic [S_WIDTH-1:0] osum_q, osum_d;
    logic               ovf_q, ovf_d;
    logic               ovalid_q;

    logic               w_sign, a_sign, p_sign;
    logic [P_WIDTH-1:0] w_ext, a_ext;
    logic [S_WIDTH-1:0] prod_ext;
    logic [S_WIDTH:0]   add_raw;
    logic               ovf_raw;
    logic [S_WIDTH-1:0] sat_val;

    // Operands are extended to the full product width so one multiplier
    // serves both signed and unsigned modes (low bits are identical).
    assign w_sign = (SIGNED != 0) & active_q[W_WIDTH-1];
    assign a_sign = (SIGNED != 0) & i_activation[A_WIDTH-1];
    assign w_ext  = {{A_WIDTH{w_sign}}, active_q};
    assign a_ext  = {{W_WIDTH{a_sign}}, i_activation};
    assign p_sign = (SIGNED != 0) & prod_q[P_WIDTH-1];

    generate
        if (S_WIDTH > P_WIDTH) begin : g_ext
            assign prod_ext = {{(S_WIDTH-P_WIDTH){p_sign}}, prod_q};
        end else begin : g_noext
            assign prod_ext = prod_q[S_WIDTH-1:0];
        end
    endgenerate

    // Weight shadow/active next-state; a same-edge swap takes the old shadow.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (i_weight_load) shadow_d = i_weight;
        if (i_weight_swap) active_d = shadow_q;
    end

    // Stage 1 captures the product and incoming sum only for valid samples.
    always_comb begin
        prod_d = prod_q;
        sum_d  = sum_q;
        if (i_valid) begin
            prod_d = w_ext * a_ext;
            sum_d  = i_sum;
        end
    end

    // Stage 2 add with overflow detection and optional clamping.
    always_comb begin
        add_raw = {1'b0, sum_q} + {1'b0, prod_ext};
        if (SIGNED != 0) begin
            ovf_raw = (sum_q[S_WIDTH-1] == prod_ext[S_WIDTH-1]) &&
                      (add_raw[S_WIDTH-1] != sum_q[S_WIDTH-1]);
            sat_val = sum_q[S_WIDTH-1] ? {1'b1, {(S_WIDTH-1){1'b0}}}
                                       : {1'b0, {(S_WIDTH-1){1'b1}}};
        end else begin
            ovf_raw = add_raw[S_WIDTH];
            sat_val = '1;
        end
        osum_d = osum_q;
        ovf_d  = 1'b0;
        if (v1_q) begin
            ovf_d = ovf_raw;
            if ((SATURATE != 0) && ovf_raw) osum_d = sat_val;
            else                            osum_d = add_raw[S_WIDTH-1:0];
        end
    end

    // Weight registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Unconditional rightward forwarding of activation and valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_q   <= '0;
            act_v_q <= 1'b0;
        end else begin
            act_q   <= i_activation;
            act_v_q <= i_valid;
        end
    end

    // Two-stage multiply/accumulate pipeline.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod_q   <= '0;
            sum_q    <= '0;
            v1_q     <= 1'b0;
            osum_q   <= '0;
            ovf_q    <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            sum_q    <= sum_d;
            v1_q     <= i_valid;
            osum_q   <= osum_d;
            ovf_q    <= ovf_d;
            ovalid_q <= v1_q;
        end
    end

    assign o_weight     = shadow_q;
    assign o_activation = act_q;
    assign o_act_valid  = act_v_q;
    assign o_sum        = osum_q;
    assign o_valid      = ovalid_q;
    assign o_ovf        = ovf_q;

endmodule

// File: tb/tb_pe_ws_param.sv
// Directed bench for pe_ws_param: four instances cover the
// signed/unsigned x wrap/saturate combinations with shared stimulus.
module tb_pe_ws_param;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  i_weight = '0;
    logic        i_weight_load = 1'b0;
    logic        i_weight_swap = 1'b0;
    logic        i_valid = 1'b0;
    logic [7:0]  i_activation = '0;
    logic [23:0] i_sum = '0;

    logic [7:0]  o_weight [4];
    logic [7:0]  o_activation [4];
    logic        o_act_valid [4];
    logic [23:0] o_sum [4];
    logic        o_valid [4];
    logic        o_ovf [4];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // index 0: unsigned wrap, 1: unsigned sat, 2: signed wrap, 3: signed sat
    pe_ws_param #(.SIGNED(0), .SATURATE(0)) u_uw (
        .clock(clock), .reset(reset), .i_weight(i_weight),
        .i_weight_load(i_weight_load), .i_weight_swap(i_weight_swap),
        .i_valid(i_valid), .i_activation(i_activation), .i_sum(i_sum),
        .o_weight(o_weight[0]), .o_activation(o_activation[0]),
        .o_act_valid(o_act_valid[0]), .o_sum(o_sum[0]),
        .o_valid(o_valid[0]), .o_ovf(o_ovf[0]));
    pe_ws_param #(.SIGNED(0), .SATURATE(1)) u_us (
        .clock(clock), .reset(reset), .i_weight(i_weight),
        .i_weight_load(i_weight_load), .i_weight_swap(i_weight_swap),
        .i_valid(i_valid), .i_activation(i_activation), .i_sum(i_sum),
        .o_weight(o_weight[1]), .o_activation(o_activation[1]),
        .o_act_valid(o_act_valid[1]), .o_sum(o_sum[1]),
        .o_valid(o_valid[1]), .o_ovf(o_ovf[1]));
    pe_ws_param #(.SIGNED(1), .SATURATE(0)) u_sw (
        .clock(clock), .reset(reset), .i_weight(i_weight),
        .i_weight_load(i_weight_load), .i_weight_swap(i_weight_swap),
        .i_valid(i_valid), .i_activation(i_activation), .i_sum(i_sum),
        .o_weight(o_weight[2]), .o_activation(o_activation[2]),
        .o_act_valid(o_act_valid[2]), .o_sum(o_sum[2]),
        .o_valid(o_valid[2]), .o_ovf(o_ovf[2]));
    pe_ws_param #(.SIGNED(1), .SATURATE(1)) u_ss (
        .clock(clock), .reset(reset), .i_weight(i_weight),
        .i_weight_load(i_weight_load), .i_weight_swap(i_weight_swap),
        .i_valid(i_valid), .i_activation(i_activation), .i_sum(i_sum),
        .o_weight(o_weight[3]), .o_activation(o_activation[3]),
        .o_act_valid(o_act_valid[3]), .o_sum(o_sum[3]),
        .o_valid(o_valid[3]), .o_ovf(o_ovf[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_w(input logic [7:0] w);
        i_weight = w;
        i_weight_load = 1'b1;
        step();
        i_weight_load = 1'b0;
        i_weight_swap = 1'b1;
        step();
        i_weight_swap = 1'b0;
    endtask

    // one valid sample, then two edges so its result sits on o_sum
    task automatic run_one(input logic [7:0] a, input logic [23:0] s);
        i_valid = 1'b1;
        i_activation = a;
        i_sum = s;
        step();
        i_valid = 1'b0;
        step();
    endtask

    task automatic chk_res(input string tag, input int k, input logic [23:0] es,
                           input logic ev, input logic eo);
        chk($sformatf("%s[%0d].sum", tag, k), 32'(o_sum[k]), 32'(es));
        chk($sformatf("%s[%0d].valid", tag, k), 32'(o_valid[k]), 32'(ev));
        chk($sformatf("%s[%0d].ovf", tag, k), 32'(o_ovf[k]), 32'(eo));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        for (int k = 0; k < 4; k++) begin
            chk_res("rst", k, 24'h0, 1'b0, 1'b0);
            chk($sformatf("rst[%0d].w", k), 32'(o_weight[k]), 32'h0);
        end
        #4 reset = 1'b0;
        step();

        // basic MAC
        load_w(8'h03);
        chk("t1.oweight", 32'(o_weight[0]), 32'h03);
        i_valid = 1'b1; i_activation = 8'h05; i_sum = 24'h000010;
        step();
        chk("t1.lat1.valid", 32'(o_valid[0]), 32'h0);
        chk("t1.fwd.act", 32'(o_activation[0]), 32'h05);
        chk("t1.fwd.v", 32'(o_act_valid[0]), 32'h1);
        i_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++) chk_res("t1", k, 24'h00001F, 1'b1, 1'b0);

        // 0xFF x 0xFF + 0xFFFFFF
        load_w(8'hFF);
        run_one(8'hFF, 24'hFFFFFF);
        chk_res("t2", 0, 24'h00FE00, 1'b1, 1'b1);
        chk_res("t2", 1, 24'hFFFFFF, 1'b1, 1'b1);
        chk_res("t2", 2, 24'h000000, 1'b1, 1'b0);
        chk_res("t2", 3, 24'h000000, 1'b1, 1'b0);

        // signed corner products
        load_w(8'h80);
        run_one(8'h7F, 24'h000000);
        chk_res("t3a", 0, 24'h003F80, 1'b1, 1'b0);
        chk_res("t3a", 1, 24'h003F80, 1'b1, 1'b0);
        chk_res("t3a", 2, 24'hFFC080, 1'b1, 1'b0);
        chk_res("t3a", 3, 24'hFFC080, 1'b1, 1'b0);
        run_one(8'h80, 24'h7FFFFF);
        chk_res("t3b", 0, 24'h803FFF, 1'b1, 1'b0);
        chk_res("t3b", 1, 24'h803FFF, 1'b1, 1'b0);
        chk_res("t3b", 2, 24'h803FFF, 1'b1, 1'b1);
        chk_res("t3b", 3, 24'h7FFFFF, 1'b1, 1'b1);
        step();
        chk_res("t3c", 2, 24'h803FFF, 1'b0, 1'b0);
        chk_res("t3c", 3, 24'h7FFFFF, 1'b0, 1'b0);

        // simultaneous load and swap: active=3, shadow=2 beforehand
        load_w(8'h03);
        i_weight = 8'h02; i_weight_load = 1'b1;
        step();
        i_weight_load = 1'b0;
        i_weight = 8'h09; i_weight_load = 1'b1; i_weight_swap = 1'b1;
        i_valid = 1'b1; i_activation = 8'h01; i_sum = 24'h0;
        step();
        i_weight_load = 1'b0; i_weight_swap = 1'b0;
        chk("t4.oweight1", 32'(o_weight[0]), 32'h09);
        step();
        i_valid = 1'b0;
        chk_res("t4a", 0, 24'h000003, 1'b1, 1'b0);
        chk("t4.oweight2", 32'(o_weight[0]), 32'h09);
        step();
        chk_res("t4b", 0, 24'h000002, 1'b1, 1'b0);
        chk_res("t4b", 2, 24'h000002, 1'b1, 1'b0);
        chk("t4.oweight3", 32'(o_weight[0]), 32'h09);

        // bubbles: valid 1,0,1
        load_w(8'h02);
        i_valid = 1'b1; i_activation = 8'h01; i_sum = 24'hFFFFFF;
        step();
        i_valid = 1'b0; i_activation = 8'h07; i_sum = 24'h000050;
        step();
        chk_res("t5a", 0, 24'h000001, 1'b1, 1'b1);
        chk_res("t5a", 1, 24'hFFFFFF, 1'b1, 1'b1);
        chk_res("t5a", 2, 24'h000001, 1'b1, 1'b0);
        chk("t5.fwd.act", 32'(o_activation[0]), 32'h07);
        chk("t5.fwd.v", 32'(o_act_valid[0]), 32'h0);
        i_valid = 1'b1; i_activation = 8'h04; i_sum = 24'h000000;
        step();
        chk_res("t5b", 0, 24'h000001, 1'b0, 1'b0);
        chk_res("t5b", 1, 24'hFFFFFF, 1'b0, 1'b0);
        i_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++) chk_res("t5c", k, 24'h000008, 1'b1, 1'b0);
        step();
        chk("t5d.valid", 32'(o_valid[0]), 32'h0);

        // async reset with samples in flight
        i_valid = 1'b1; i_activation = 8'h01; i_sum = 24'h000005;
        step();
        i_activation = 8'h02; i_sum = 24'h000006;
        step();
        i_activation = 8'h03;
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) chk_res("t6rst", k, 24'h0, 1'b0, 1'b0);
        chk("t6rst.w", 32'(o_weight[0]), 32'h0);
        chk("t6rst.act", 32'(o_activation[0]), 32'h0);
        chk("t6rst.actv", 32'(o_act_valid[0]), 32'h0);
        i_valid = 1'b0;
        #2 reset = 1'b0;
        step();
        step();
        chk("t6.novalid", 32'(o_valid[0]), 32'h0);
        load_w(8'h04);
        i_valid = 1'b1; i_activation = 8'h03; i_sum = 24'h000001;
        step();
        i_valid = 1'b0;
        chk("t6.lat1", 32'(o_valid[0]), 32'h0);
        step();
        chk_res("t6", 0, 24'h00000D, 1'b1, 1'b0);
        chk_res("t6", 3, 24'h00000D, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
